// File: rtl/eth_rx_pkg.sv
// Shared constants for the RMII receive deframer: FSM encodings, dibit codes, CRC-32 parameters.
package eth_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t PREAMBLE = 3'd1;
  localparam state_t DATA     = 3'd2;
  localparam state_t DROP     = 3'd3;
  localparam state_t DONE     = 3'd4;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] crc_reflect(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_rmii_rx_if.sv
// Receive-buffer write port and frame status bundle between the RMII deframer and the host side.
interface eth_rmii_rx_if #(parameter int BUF_AW = 11);

  logic              wr_en;
  logic [BUF_AW-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              frm_valid;
  logic [BUF_AW-1:0] frm_len;
  logic              frm_err;
  logic              crc_err;
  logic [7:0]        drop_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, frm_valid, frm_len, frm_err, crc_err, drop_cnt
  );

  modport slave (
    input wr_en, wr_addr, wr_data, frm_valid, frm_len, frm_err, crc_err, drop_cnt
  );

endinterface

// File: rtl/eth_crc32.sv
// Byte-wide reflected Ethernet CRC-32 register with synchronous clear and update enable.
module eth_crc32
  import eth_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY_REF = crc_reflect(CRC_POLY);

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ POLY_REF) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) crc <= CRC_INIT;
    else if (en)      crc <= crc_next(crc, data);
  end

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII receive deframer: strips preamble/SFD, writes payload+FCS bytes, reports length/status.
// Optional FCS check enabled by defining ETH_RX_CRC_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for CRS_DV with a preamble dibit
// PREAMBLE | consuming 01 dibits until the SFD's closing 11
// DATA     | assembling bytes and writing them to the buffer
// DONE     | single cycle carrying the end-of-frame pulse
// DROP     | discarding the rest of the frame until CRS_DV falls
module eth_rmii_rx
  import eth_rx_pkg::*;
#(
  parameter int BUF_AW  = 11,
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_erxd,
  input  logic       i_erx_dv,
  input  logic       i_erx_er,
  input  logic       i_buf_busy,
  eth_rmii_rx_if.master rx
);

  state_t            state;
  logic [1:0]        phase;
  logic [5:0]        shift;
  logic [BUF_AW-1:0] cnt;
  logic              er_flag;

  logic [7:0] byte_now;
  logic       byte_done;
  logic       over;
  logic       sfd_ok;
  logic       crc_bad;

  assign byte_now  = {i_erxd, shift};
  assign byte_done = (state == DATA) && i_erx_dv && (phase == 2'd3);
  assign over      = (cnt == BUF_AW'(MAX_LEN));
  assign sfd_ok    = (state == PREAMBLE) && i_erx_dv && (i_erxd == SFD_DIBIT) && !i_buf_busy;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q;

  eth_crc32 u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (sfd_ok),
    .en    (byte_done && !over),
    .data  (byte_now),
    .crc   (crc_q)
  );

  // The register runs reflected; the residue constant is in unreflected bit order.
  assign crc_bad = (crc_reflect(crc_q) != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= 2'd0;
      shift        <= 6'd0;
      cnt          <= '0;
      er_flag      <= 1'b0;
      rx.wr_en     <= 1'b0;
      rx.wr_addr   <= '0;
      rx.wr_data   <= 8'd0;
      rx.frm_valid <= 1'b0;
      rx.frm_len   <= '0;
      rx.frm_err   <= 1'b0;
      rx.crc_err   <= 1'b0;
      rx.drop_cnt  <= 8'd0;
    end else begin
      rx.wr_en     <= 1'b0;
      rx.frm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_erx_dv && i_erxd == PRE_DIBIT) state <= PREAMBLE;
        end
        PREAMBLE: begin
          if (!i_erx_dv) begin
            state <= IDLE;
          end else if (i_erxd == SFD_DIBIT) begin
            phase   <= 2'd0;
            cnt     <= '0;
            er_flag <= 1'b0;
            if (i_buf_busy) begin
              state <= DROP;
              if (rx.drop_cnt != 8'hFF) rx.drop_cnt <= rx.drop_cnt + 8'd1;
            end else begin
              state <= DATA;
            end
          end else if (i_erxd != PRE_DIBIT) begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!i_erx_dv) begin
            // Status is registered here so the pulse lands in the DONE cycle.
            state        <= DONE;
            rx.frm_valid <= 1'b1;
            rx.frm_len   <= cnt;
            rx.crc_err   <= crc_bad;
            rx.frm_err   <= er_flag | (phase != 2'd0) | (cnt < BUF_AW'(MIN_LEN)) | crc_bad;
          end else begin
            if (i_erx_er) er_flag <= 1'b1;
            shift <= {i_erxd, shift[5:2]};
            phase <= phase + 2'd1;
            if (byte_done) begin
              if (over) begin
                state <= DROP;
                if (rx.drop_cnt != 8'hFF) rx.drop_cnt <= rx.drop_cnt + 8'd1;
              end else begin
                rx.wr_en   <= 1'b1;
                rx.wr_addr <= cnt;
                rx.wr_data <= byte_now;
                cnt        <= cnt + 1'b1;
              end
            end
          end
        end
        DONE: state <= IDLE;
        DROP: begin
          if (!i_erx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_rmii_rx.md
# eth_rmii_rx

RMII receive deframer for the Ethernet MAC in `eth_top`, and the counterpart of the transmit path that drives `o_etx_en`. It samples 2-bit RMII receive dibits at 100 Mb/s and strips the preamble and SFD. It writes payload bytes (including FCS) into the receive frame buffer through a byte write port, then reports frame length and status to the host-side AXI register block.

## Interface
Parameters:
- `BUF_AW`, 11: receive buffer byte-address width; also the width of `o_frm_len`.
- `MAX_LEN`, 1518: largest accepted frame in bytes, counted from DA through FCS.
- `MIN_LEN`, 64: shorter frames are flagged as runts.

Ports:
- `clk` in 1: 50 MHz RMII reference clock. The block has one clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `i_erxd` in 2: RMII RXD. The dibit is sampled on `clk` rising edge.
- `i_erx_dv` in 1: RMII CRS_DV.
- `i_erx_er` in 1: RMII RX_ER.
- `i_buf_busy` in 1: high while the host still owns the previous frame.
- `o_wr_en` out 1: buffer byte write strobe.
- `o_wr_addr` out `BUF_AW`: byte address. It is 0 for the first byte after SFD.
- `o_wr_data` out 8: byte to write.
- `o_frm_valid` out 1: one-cycle pulse that marks the end of an accepted frame.
- `o_frm_len` out `BUF_AW`: byte count of the frame, valid with `o_frm_valid` and held until the next pulse.
- `o_frm_err` out 1: error summary, valid with `o_frm_valid`.
- `o_crc_err` out 1: FCS mismatch, valid with `o_frm_valid`.
- `o_drop_cnt` out 8: saturating count of dropped frames.

## Operation
Bit order:
- Dibits arrive LSB first.
- A byte is `{d3,d2,d1,d0}`, where `d0` is the first dibit received.

States:
- **IDLE**
  - `i_erx_dv`=1 with `i_erxd`=01 → PREAMBLE.
- **PREAMBLE**
  - `i_erxd`=01 → stay.
  - `i_erxd`=11 (final dibit of SFD) → DATA, with dibit phase and byte count cleared.
    - If `i_buf_busy`=1 at this cycle, go to DROP instead and increment `o_drop_cnt`.
  - Any other dibit → DROP (no count).
  - `i_erx_dv`=0 → IDLE.
- **DATA**
  - Shift one dibit per cycle.
  - On phase 3, write the completed byte at address = byte count, then increment the count.
  - An `i_erx_er`=1 sample sets a sticky error flag.
  - If the count would exceed `MAX_LEN`, go to DROP and increment `o_drop_cnt`. No `o_frm_valid` is generated and the partial buffer contents are ignored.
  - `i_erx_dv`=0 → DONE.
    - If the dibit phase is nonzero, the partial byte is discarded and the dribble flag is set.
- **DONE** (exactly one cycle)
  - Pulse `o_frm_valid`, latch `o_frm_len`, go to IDLE.
  - `o_frm_err` = `er` | dribble | (len < `MIN_LEN`) | `o_crc_err`.
- **DROP**
  - Wait for `i_erx_dv`=0 → IDLE.

Arithmetic and counters:
- The byte count is `BUF_AW` bits wide. `MAX_LEN` must be < 2^`BUF_AW`, so the address never wraps.
- `o_drop_cnt` saturates at 255 and clears only on `rst`.

## Timing
- Reset values:
  - All outputs are 0.
  - State = IDLE; flags and counters are cleared.
- Write latency:
  - The 4th dibit of a byte is sampled at cycle N.
  - `o_wr_en`, `o_wr_addr` and `o_wr_data` are registered and valid at N+1, for one cycle.
- End of frame:
  - `i_erx_dv` is sampled low in DATA at cycle M; the last byte write is at or before M.
  - `o_frm_valid` is high at M+1. It is always after the final write, and a frame never produces both in the same cycle.
- Back-to-back frames:
  - A new preamble may start in the cycle after DONE.
  - A preamble dibit sampled during DONE is ignored.
- `i_buf_busy` is sampled only at SFD. Changes mid-frame do not affect the frame in progress.
- Reset asserted mid-frame:
  - Takes effect at the next edge.
  - No `o_frm_valid` is produced for the interrupted frame.

## Configuration
- `ETH_RX_CRC_CHECK_EN` defined:
  - A CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated on every written byte, including FCS.
  - At DONE, `o_crc_err` = (register != residue 0xC704DD7B).
- Not defined:
  - No CRC logic is generated.
  - `o_crc_err` is constant 0; `o_frm_err` ignores CRC.
  - The FCS bytes are still written and counted.

## Structure
- Package `eth_rx_pkg` holds:
  - the state enum (IDLE, PREAMBLE, DATA, DROP, DONE);
  - dibit constants `PRE_DIBIT`=2'b01 and `SFD_DIBIT`=2'b11;
  - `CRC_POLY`, `CRC_INIT` and `CRC_RESIDUE`.
- Sub-module `eth_crc32`:
  - Byte-wide combinational next-CRC function plus its register, with `clear` and `en` inputs.
  - Instantiated only under `ETH_RX_CRC_CHECK_EN`.

## Test plan
- **Good frame:** 7×0x55, SFD 0xD5, then 64 bytes with a valid FCS (`i_buf_busy`=0) → 64 writes at addresses 0..63 in order, then `o_frm_valid` with len=64, `o_frm_err`=0, `o_crc_err`=0.
- **CRC error:** the same frame with byte 10 XORed with 0x01 → len=64, `o_crc_err`=1, `o_frm_err`=1. With the macro undefined, `o_crc_err`=0 and `o_frm_err`=0.
- **Busy drop:** `i_buf_busy`=1 at SFD → no writes, no `o_frm_valid`, `o_drop_cnt` 0→1. 300 such frames → count saturates at 255.
- **Oversize:** a 1519-byte frame → writes stop after address 1517, no `o_frm_valid`, `o_drop_cnt` +1.
- **Runt, dribble and RX_ER:**
  - 40-byte frame → len=40, `o_frm_err`=1.
  - 64 bytes plus 2 extra dibits → len=64, `o_frm_err`=1.
  - `i_erx_er` pulsed at byte 20 → len=64, `o_frm_err`=1.
- **Reset mid-frame:** `rst` asserted at byte 30 for 1 cycle → all outputs 0 on the next edge and no `o_frm_valid`. The following good 64-byte frame is received with len=64 and `o_frm_err`=0.
